// File: rtl/gray_fifo_reader_if.sv
// -----------------------------------------------------------------------------
// gray_fifo_reader_if
// Valid/ready stream that carries words out of the gray FIFO reader.
//   data  : payload, WIDTH bits
//   valid : producer has a word on data
//   ready : consumer accepts the word; a transfer happens when valid && ready
// Modports:
//   master : the producer (the reader), drives data/valid, samples ready
//   slave  : the consumer, samples data/valid, drives ready
// -----------------------------------------------------------------------------
interface gray_fifo_reader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/gray_fifo_reader.sv
// -----------------------------------------------------------------------------
// gray_fifo_reader
// Read-side controller of a gray-pointer FIFO. The storage array and the write
// pointer belong to a writer in another clock domain. This block synchronises
// the gray write pointer, pops words out of the exposed storage into a 2-entry
// spill buffer, streams them on a valid/ready interface and returns its own
// gray read pointer to the writer straight from a flop.
//
// Ports:
//   dst_clk_i    : clock, all state on the rising edge
//   dst_rst_ni   : synchronous active-low reset
//   flush_i      : (only with GRAY_FIFO_READER_FLUSH_EN) drop all unread words
//   async_data_i : storage, entry i at [i*WIDTH +: WIDTH]
//   async_wptr_i : writer gray pointer, asynchronous to dst_clk_i
//   async_rptr_o : reader gray pointer, registered
//   dst          : output stream (master modport of gray_fifo_reader_if)
//   fill_o       : words in storage not yet popped (spill entries excluded)
//
// Optional feature macro: GRAY_FIFO_READER_FLUSH_EN adds flush_i. When it is
// undefined there is no flush port and no flush logic.
// -----------------------------------------------------------------------------

// Flags a writer that overfills the storage (fill beyond the depth).
module gray_fifo_reader_chk #(
  parameter int PW    = 4,
  parameter int DEPTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  input logic [PW-1:0] fill
);
  // Fill may reach the depth but never exceed it.
  a_no_overfill: assert property (@(posedge clk) disable iff (!rst_n) (fill <= PW'(DEPTH)));
endmodule

module gray_fifo_reader #(
  parameter int WIDTH       = 8,
  parameter int LOG_DEPTH   = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              dst_clk_i,
  input  logic                              dst_rst_ni,
`ifdef GRAY_FIFO_READER_FLUSH_EN
  input  logic                              flush_i,
`endif
  input  logic [WIDTH*(2**LOG_DEPTH)-1:0]   async_data_i,
  input  logic [LOG_DEPTH:0]                async_wptr_i,
  output logic [LOG_DEPTH:0]                async_rptr_o,
  gray_fifo_reader_if.master                dst,
  output logic [LOG_DEPTH:0]                fill_o
);

  localparam int PW    = LOG_DEPTH + 1;
  localparam int DEPTH = 2 ** LOG_DEPTH;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  // Gray to binary: each binary bit is the xor of all gray bits at or above it.
  function automatic logic [PW-1:0] gray_to_bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to gray.
  function automatic logic [PW-1:0] bin_to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [PW-1:0]    sync_r [SYNC_STAGES];
  logic [PW-1:0]    rptr_r;
  logic [WIDTH-1:0] a_data_r, b_data_r;
  logic             a_valid_r, b_valid_r;

  logic [PW-1:0]    rptr_nxt_s;
  logic [WIDTH-1:0] a_data_nxt_s, b_data_nxt_s;
  logic             a_valid_nxt_s, b_valid_nxt_s;

  logic [WIDTH-1:0] mem_s [DEPTH];
  logic [PW-1:0]    wptr_bin_s, rptr_bin_s, fill_s;
  logic [WIDTH-1:0] rd_word_s;
  logic             empty_s, pop_s, drain_s;

  // Storage viewed as an array of words.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    assign mem_s[gi] = async_data_i[gi*WIDTH +: WIDTH];
  end

  // Synchroniser for the writer pointer; every bit passes SYNC_STAGES flops.
  always_ff @(posedge dst_clk_i) begin
    if (!dst_rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= {PW{1'b0}};
      end
    end else begin
      sync_r[0] <= async_wptr_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  // Occupancy and pop decision; popping stops whenever B holds a word.
  always_comb begin
    wptr_bin_s = gray_to_bin(sync_r[SYNC_STAGES-1]);
    rptr_bin_s = gray_to_bin(rptr_r);
    fill_s     = wptr_bin_s - rptr_bin_s;
    empty_s    = (fill_s == {PW{1'b0}});
    pop_s      = !empty_s && !b_valid_r;
    drain_s    = a_valid_r && dst.ready;
    rd_word_s  = mem_s[rptr_bin_s[LOG_DEPTH-1:0]];
  end

  // Next pointer and spill-buffer contents. B is only ever occupied while A is.
  always_comb begin
    rptr_nxt_s    = rptr_r;
    a_data_nxt_s  = a_data_r;
    a_valid_nxt_s = a_valid_r;
    b_data_nxt_s  = b_data_r;
    b_valid_nxt_s = b_valid_r;

    if (pop_s) begin
      rptr_nxt_s = bin_to_gray(rptr_bin_s + PTR_ONE);
    end else begin
      rptr_nxt_s = rptr_r;
    end

    if (drain_s) begin
      if (b_valid_r) begin
        // pop_s is low here because B is full.
        a_data_nxt_s  = b_data_r;
        a_valid_nxt_s = 1'b1;
        b_valid_nxt_s = 1'b0;
      end else if (pop_s) begin
        a_data_nxt_s  = rd_word_s;
        a_valid_nxt_s = 1'b1;
      end else begin
        a_valid_nxt_s = 1'b0;
      end
    end else begin
      if (pop_s && !a_valid_r) begin
        a_data_nxt_s  = rd_word_s;
        a_valid_nxt_s = 1'b1;
      end else if (pop_s) begin
        b_data_nxt_s  = rd_word_s;
        b_valid_nxt_s = 1'b1;
      end else begin
        b_valid_nxt_s = b_valid_r;
      end
    end

`ifdef GRAY_FIFO_READER_FLUSH_EN
    // Flush jumps the read pointer to the synchronised write pointer and
    // empties the spill buffer, taking precedence over pop and drain.
    if (flush_i) begin
      rptr_nxt_s    = bin_to_gray(wptr_bin_s);
      a_valid_nxt_s = 1'b0;
      b_valid_nxt_s = 1'b0;
    end else begin
      rptr_nxt_s = rptr_nxt_s;
    end
`endif
  end

  // Read pointer and spill-buffer registers.
  always_ff @(posedge dst_clk_i) begin
    if (!dst_rst_ni) begin
      rptr_r    <= {PW{1'b0}};
      a_data_r  <= {WIDTH{1'b0}};
      a_valid_r <= 1'b0;
      b_data_r  <= {WIDTH{1'b0}};
      b_valid_r <= 1'b0;
    end else begin
      rptr_r    <= rptr_nxt_s;
      a_data_r  <= a_data_nxt_s;
      a_valid_r <= a_valid_nxt_s;
      b_data_r  <= b_data_nxt_s;
      b_valid_r <= b_valid_nxt_s;
    end
  end

  assign async_rptr_o = rptr_r;
  assign dst.data     = a_data_r;
  assign dst.valid    = a_valid_r;
  assign fill_o       = fill_s;

  gray_fifo_reader_chk #(
    .PW    (PW),
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (dst_clk_i),
    .rst_n (dst_rst_ni),
    .fill  (fill_s)
  );

endmodule
